// File: rtl/clock_boundary_tx_pkg.sv
// Shared constants and types for the hring clock-boundary transmit side.
// Link width matches the receiver's control_w port.
package clock_boundary_tx_pkg;

  localparam int CONTROL_W       = 128;
  localparam int FLIT_VALID_BIT  = CONTROL_W - 1;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_CREDITS = 4;

  // Decoded from {credit_i, send}; a return and a spend in the same cycle cancel.
  typedef enum logic [1:0] {
    CR_HOLD   = 2'b00,
    CR_SPEND  = 2'b01,
    CR_RETURN = 2'b10,
    CR_BOTH   = 2'b11
  } credit_op_e;

endpackage

// File: rtl/clock_boundary_tx_fifo.sv
// boundary_fifo: synchronous DEPTH x WIDTH FIFO with a combinational head.
// Full/empty come from an occupancy counter so pointers can wrap naturally.
module boundary_fifo
  import clock_boundary_tx_pkg::*;
#(
  parameter int WIDTH = CONTROL_W,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (occupancy == OW'(DEPTH));
  assign empty = (occupancy == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/clock_boundary_tx.sv
// Transmit side of the hring clock-boundary link: buffers ring-stop flits and
// launches at most one per cycle onto a registered link, gated by receiver credits.
module clock_boundary_tx
  import clock_boundary_tx_pkg::*;
#(
  parameter int WIDTH   = CONTROL_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int CREDITS = DEFAULT_CREDITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_flit,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             port0_co,
  input  logic                         credit_i,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         err_credit
);

  localparam int CW = $clog2(CREDITS+1);

  logic             push;
  logic             send;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] launch;
  credit_op_e       credit_op;

  boundary_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (send),
    .wdata     (in_flit),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  // in_ready reflects occupancy before the edge, so a pop never frees a slot early.
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign send     = ~empty & (credit_cnt != '0);

  always_comb begin
    launch            = head;
    launch[WIDTH-1]   = 1'b1;
    credit_op         = credit_op_e'({credit_i, send});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CW'(CREDITS);
      err_credit <= 1'b0;
      port0_co   <= '0;
    end else begin
      case (credit_op)
        CR_RETURN: begin
          if (credit_cnt == CW'(CREDITS)) err_credit <= 1'b1;
          else                            credit_cnt <= credit_cnt + CW'(1);
        end
        CR_SPEND: credit_cnt <= credit_cnt - CW'(1);
        default:  credit_cnt <= credit_cnt;
      endcase
      // Bubble on every idle cycle so the receiver never sees stale data.
      port0_co <= send ? launch : '0;
    end
  end

endmodule

// File: tb/tb_clock_boundary_tx.sv
// Scoreboard bench for clock_boundary_tx: expected flits are queued on push and
// popped by a monitor whenever the link shows a valid flit.
`timescale 1ns/1ps
module tb_clock_boundary_tx;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_flit;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] port0_co;
  logic         credit_i;
  logic [2:0]   credit_cnt;
  logic [2:0]   occupancy;
  logic         err_credit;

  int vectors = 0;
  int errors  = 0;
  logic [127:0] exp_q[$];

  clock_boundary_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_flit    (in_flit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .port0_co   (port0_co),
    .credit_i   (credit_i),
    .credit_cnt (credit_cnt),
    .occupancy  (occupancy),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] vflit(input logic [127:0] f);
    logic [127:0] r;
    r = f;
    r[127] = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one flit for the coming edge; accept says whether the FIFO should take it.
  task automatic drive_flit(input logic [127:0] f, input bit accept);
    in_valid = 1'b1;
    in_flit  = f;
    if (accept) exp_q.push_back(vflit(f));
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && port0_co[127] === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL link_unexpected: got %h expected no flit", port0_co);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (port0_co !== e) begin
          errors++;
          $display("FAIL link_flit: got %h expected %h", port0_co, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] f;
    rst = 1'b0; in_valid = 1'b1; credit_i = 1'b1;
    in_flit = 128'hdead_beef_0000_0000_0000_0000_cafe_f00d;

    // Reset holds everything idle despite active inputs.
    repeat (3) tick();
    check("rst_port0", port0_co, '0);
    check("rst_credit", credit_cnt, 4);
    check("rst_occ", occupancy, 0);
    check("rst_ready", in_ready, 1);
    check("rst_err", err_credit, 0);
    in_valid = 1'b0; credit_i = 1'b0; rst = 1'b1;
    repeat (3) tick();
    check("idle_port0", port0_co, '0);
    check("idle_occ", occupancy, 0);

    // Single flit: two-edge latency, then bubble.
    drive_flit(128'h0123456789abcdef0123456789abcdef, 1'b1);
    tick();
    in_valid = 1'b0;
    check("single_n_port0", port0_co, '0);
    check("single_n_occ", occupancy, 1);
    tick();
    check("single_n1_port0", port0_co, 128'h8123456789abcdef0123456789abcdef);
    check("single_credit", credit_cnt, 3);
    tick();
    check("single_n2_port0", port0_co, '0);
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    check("single_credit_back", credit_cnt, 4);

    // Credit starvation: 6 flits, only 4 credits.
    for (int i = 0; i < 6; i++) begin
      f = {8'hb0, 88'h0, 32'(i)};
      drive_flit(f, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("starve_occ", occupancy, 2);
    check("starve_credit", credit_cnt, 0);
    tick(); tick();
    check("starve_port0_idle", port0_co, '0);
    check("starve_occ_hold", occupancy, 2);
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    check("starve_credit_ret", credit_cnt, 1);
    check("starve_no_bypass", port0_co, '0);
    tick();
    check("starve_release", port0_co, vflit({8'hb0, 88'h0, 32'd4}));
    check("starve_credit_used", credit_cnt, 0);
    check("starve_occ_one", occupancy, 1);
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    tick(); tick();
    check("drain_occ", occupancy, 0);
    check("drain_credit", credit_cnt, 0);

    // Full FIFO with no credits: fifth push refused.
    for (int i = 0; i < 5; i++) begin
      f = {8'hc0, 88'h0, 32'(i)};
      drive_flit(f, i < 4);
      tick();
    end
    in_valid = 1'b0;
    check("full_occ", occupancy, 4);
    check("full_ready", in_ready, 0);
    tick();
    check("full_port0", port0_co, '0);
    credit_i = 1'b1;
    repeat (4) tick();
    credit_i = 1'b0;
    tick(); tick();
    check("full_drained_occ", occupancy, 0);
    check("full_drained_credit", credit_cnt, 0);
    credit_i = 1'b1;
    repeat (4) tick();
    credit_i = 1'b0;
    check("restore_credit", credit_cnt, 4);
    check("restore_err", err_credit, 0);

    // Streaming with a credit returned on every send edge.
    drive_flit({8'h5d, 88'h0, 32'd0}, 1'b1);
    tick();
    for (int i = 1; i < 8; i++) begin
      drive_flit({8'h5d, 88'h0, 32'(i)}, 1'b1);
      credit_i = 1'b1;
      tick();
      check("stream_credit", credit_cnt, 4);
      check("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_last_credit", credit_cnt, 4);
    credit_i = 1'b0;
    tick();
    check("stream_port0_idle", port0_co, '0);
    check("stream_err", err_credit, 0);
    check("stream_occ_end", occupancy, 0);

    // Credit overflow is sticky.
    credit_i = 1'b1; tick(); credit_i = 1'b0;
    check("ovf_credit", credit_cnt, 4);
    check("ovf_err", err_credit, 1);
    tick(); tick();
    check("ovf_err_sticky", err_credit, 1);

    // Asynchronous reset mid-stream, between edges.
    for (int i = 0; i < 3; i++) begin
      drive_flit({8'h7f, 88'h0, 32'(i)}, 1'b1);
      tick();
    end
    #2;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("arst_port0", port0_co, '0);
    check("arst_err", err_credit, 0);
    check("arst_occ", occupancy, 0);
    check("arst_credit", credit_cnt, 4);
    check("arst_ready", in_ready, 1);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();

    // Clean operation after reset.
    drive_flit(128'h0000_1111_2222_3333_4444_5555_6666_7777, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("post_rst_port0", port0_co, 128'h8000_1111_2222_3333_4444_5555_6666_7777);
    check("post_rst_credit", credit_cnt, 3);
    tick(); tick();
    check("queue_empty", 128'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/clock_boundary_tx.md
Name: clock_boundary_tx

Overview:
- Transmit side of the hring clock-boundary link; feeds the receiving clock-boundary stage through its `control_w` port0 input.
- Accepts flits from the local ring stop into a small FIFO and launches at most one flit per cycle onto a registered link output.
- Flow control is credit-based: the receiver returns one credit pulse per flit slot it frees.
- Guarantees no flit is dropped at the boundary.

Parameters:
- WIDTH, 128, flit/link width; matches `control_w`; bit WIDTH-1 is the valid bit.
- DEPTH, 4, local FIFO entries; power of two, at least 2.
- CREDITS, 4, receiver buffer slots; credit counter reset value.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset; asynchronous, active-low.
- in_flit  input  WIDTH  flit from ring stop; bit WIDTH-1 ignored on input.
- in_valid  input  1  in_flit valid this cycle.
- in_ready  output  1  FIFO can accept; equals !full.
- port0_co  output  WIDTH  registered link flit to the receiver; bit WIDTH-1 = valid.
- credit_i  input  1  one-cycle credit return pulse from the receiver.
- credit_cnt  output  clog2(CREDITS+1)  current credits held.
- occupancy  output  clog2(DEPTH+1)  FIFO entries in use.
- err_credit  output  1  sticky; set on credit overflow.

Behaviour:
- Reset (rst low, async):
  - port0_co = 0.
  - FIFO empty; occupancy = 0; in_ready = 1.
  - credit_cnt = CREDITS.
  - err_credit = 0.
  - Read/write pointers = 0.
  - Reset asserted mid-transfer discards FIFO contents and any in-flight credit; no partial flit is emitted.
- Push: at a clk edge with in_valid && in_ready, write in_flit to the tail. in_valid while full is ignored (no write, no error).
- Send condition at each edge: FIFO non-empty && credit_cnt > 0.
  - On send: port0_co <= head flit with bit WIDTH-1 forced to 1; pop the head; decrement credit_cnt.
  - With no send: port0_co <= 0. The link output is a bubble every non-send cycle; stale data is never held.
- Latency: a flit pushed at edge N is visible on port0_co after edge N+1 at the earliest. There is no input-to-output bypass.
- Throughput: one flit per cycle while credits and data are available.
- Simultaneous push and pop:
  - Allowed when full; in_ready already reflects full before the edge, so a push while full is refused even if a pop occurs.
  - When empty, the pushed flit is not sent the same edge.
- Credit counter update: next = cnt + credit_i - send.
  - If credit_i and send occur together, the count is unchanged.
  - If cnt == CREDITS, credit_i arrives, and there is no send: saturate at CREDITS and set err_credit. err_credit clears only on reset.
- Pointers: log2(DEPTH) bits, natural wrap-around. Full/empty are tracked via the occupancy counter, range 0..DEPTH.
- All outputs are driven from registers except in_ready, which is combinational from occupancy.

Decomposition:
- Shared defines, alongside `control_w`:
  - FLIT_VALID_BIT (WIDTH-1).
  - Default CREDITS and DEPTH constants.
- One sub-module: boundary_fifo (synchronous FIFO, DEPTH x WIDTH).
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, occupancy; same clk/rst.
- The credit counter, send logic and output register stay in clock_boundary_tx.

Test Plan:
- Reset: hold rst low, drive in_valid=1 and credit_i=1. Expect port0_co=0, credit_cnt=4, occupancy=0, in_ready=1, err_credit=0. Release reset and expect no output until a push.
- Single flit: push in_flit=128'h0123456789abcdef0123456789abcdef at edge N. Expect port0_co=128'h8123456789abcdef0123456789abcdef after edge N+1, port0_co=0 after N+2, credit_cnt=3.
- Credit starvation: push 6 flits back-to-back with no credit_i. Expect exactly 4 flits sent on consecutive cycles and credit_cnt=0. Expect the remaining 2 to stay buffered (occupancy=2) and port0_co=0 thereafter. One credit_i pulse releases exactly one flit the following edge.
- Full FIFO: with credits at 0, push 5 flits. Expect occupancy=4, in_ready=0, and the 5th flit dropped from acceptance (not in FIFO). Return 4 credits and expect the 4 flits in original order.
- Simultaneous credit and send: stream continuously with credit_i pulsed every cycle. Expect credit_cnt held constant at 4, one flit per cycle, and no err_credit.
- Credit overflow and async reset: at credit_cnt=4 and idle, pulse credit_i. Expect credit_cnt=4 and err_credit=1 (sticky). Assert rst mid-stream between clock edges and expect immediate port0_co=0, err_credit=0, occupancy=0.
